operand_buffer: RTL and testbench

Eight-entry operand store that accepts the element-by-element load stream issued by the TPU control unit during matrix loading. It replays A (2×2) and B (2×2) into the 2×2 systolic MMU as skewed edge operands once feeding is requested. It is the responder side of the load strobe/address interface and the data source for the feed phase. It sits between the host input byte bus, the control unit and the MMU array.

---
 rtl/operand_buffer.sv | 178 +++++++++++++++++
 tb/tb_operand_buffer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_buffer.sv
// Eight-entry operand store for a 2x2 systolic MMU: accepts the element load stream and replays
// A/B as skewed edge operands. Optional build macro OPBUF_REPLAY_EN keeps the matrices after a feed.
module operand_buffer #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [2:0]        load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              feed_en,
  output logic [DATA_W-1:0] a0_out,
  output logic [DATA_W-1:0] a1_out,
  output logic [DATA_W-1:0] b0_out,
  output logic [DATA_W-1:0] b1_out,
  output logic              ops_valid,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {StEmpty, StFilling, StReady, StFeeding} state_e;

  state_e            state_q, state_d;
  logic [1:0]        ph_q, ph_d;
  logic [7:0]        vmask_q, vmask_d;
  logic              armed_q, armed_d;
  logic              err_q, err_d;
  logic              load_ok;

  logic [DATA_W-1:0] mem_q  [8];
  logic [DATA_W-1:0] mem_nx [8];

  logic [DATA_W-1:0] a0_d, a1_d, b0_d, b1_d;
  logic [DATA_W-1:0] a0_q, a1_q, b0_q, b1_q;
  logic              valid_d, valid_q;

  assign load_ok = load_en && (state_q != StFeeding);

  // Storage is deliberately not reset; only the valid mask is.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Post-edge memory view so a load coinciding with feed start is replayed correctly.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mem_nx[i] = (load_ok && (load_addr == 3'(i))) ? load_data : mem_q[i];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ph_q    <= 2'd0;
      vmask_q <= 8'h00;
      armed_q <= 1'b1;
      err_q   <= 1'b0;
      a0_q    <= '0;
      a1_q    <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      vmask_q <= vmask_d;
      armed_q <= armed_d;
      err_q   <= err_d;
      a0_q    <= a0_d;
      a1_q    <= a1_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      valid_q <= valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    vmask_d = vmask_q;
    armed_d = armed_q;
    err_d   = err_q;

    if (!feed_en) begin
      armed_d = 1'b1;
    end

    if (load_en) begin
      if (state_q == StFeeding) begin
        err_d = 1'b1;
      end else begin
        vmask_d[load_addr] = 1'b1;
        armed_d            = 1'b1;
      end
    end

    unique case (state_q)
      StEmpty, StFilling: begin
        if (vmask_d == 8'hFF) begin
          state_d = StReady;
        end else if (vmask_d == 8'h00) begin
          state_d = StEmpty;
        end else begin
          state_d = StFilling;
        end
      end
      StReady: begin
        // armed stops a feed_en that never dropped from restarting a feed.
        if (feed_en && armed_q) begin
          state_d = StFeeding;
          ph_d    = 2'd0;
          armed_d = 1'b0;
        end
      end
      StFeeding: begin
        if (ph_q == 2'd2) begin
          ph_d = 2'd0;
`ifdef OPBUF_REPLAY_EN
          state_d = StReady;
          armed_d = !feed_en;
`else
          state_d = StEmpty;
          vmask_d = 8'h00;
`endif
        end else if (!feed_en) begin
          state_d = StReady;
          ph_d    = 2'd0;
          armed_d = 1'b1;
        end else begin
          ph_d = ph_q + 2'd1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Output logic: skewed edge operands for the upcoming phase
  always_comb begin
    a0_d    = '0;
    a1_d    = '0;
    b0_d    = '0;
    b1_d    = '0;
    valid_d = 1'b0;
    if (state_d == StFeeding) begin
      valid_d = 1'b1;
      case (ph_d)
        2'd0: begin
          a0_d = mem_nx[0];
          b0_d = mem_nx[4];
        end
        2'd1: begin
          a0_d = mem_nx[1];
          a1_d = mem_nx[2];
          b0_d = mem_nx[6];
          b1_d = mem_nx[5];
        end
        2'd2: begin
          a1_d = mem_nx[3];
          b1_d = mem_nx[7];
        end
        default: valid_d = 1'b0;
      endcase
    end
  end

  assign a0_out    = a0_q;
  assign a1_out    = a1_q;
  assign b0_out    = b0_q;
  assign b1_out    = b1_q;
  assign ops_valid = valid_q;
  assign full      = (vmask_q == 8'hFF);
  assign err       = err_q;

endmodule

// File: tb/tb_operand_buffer.sv
// Self-checking bench for operand_buffer: directed scenarios plus randomized loads, checked
// against a matrix-level model of the skewed feed.
module tb_operand_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en = 1'b0;
  logic [2:0] load_addr = 3'd0;
  logic [7:0] load_data = 8'd0;
  logic       feed_en = 1'b0;
  logic [7:0] a0_out, a1_out, b0_out, b1_out;
  logic       ops_valid, full, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_mem [8];
  logic [7:0] m_vmask;

  operand_buffer #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .feed_en   (feed_en),
    .a0_out    (a0_out),
    .a1_out    (a1_out),
    .b0_out    (b0_out),
    .b1_out    (b1_out),
    .ops_valid (ops_valid),
    .full      (full),
    .err       (err)
  );

  always #5 clk = ~clk;

  wire [32:0] obs = {ops_valid, a0_out, a1_out, b0_out, b1_out};

  // A[r][c] = mem[2r+c], B[r][c] = mem[4+2r+c]; phase k feeds A[0][k], A[1][k-1], B[k][0], B[k-1][1].
  function automatic logic [32:0] exp_ops(input int k);
    logic [7:0] a0, a1, b0, b1;
    if (k > 2) return 33'd0;
    a0 = (k < 2)  ? m_mem[k]                 : 8'd0;
    a1 = (k >= 1) ? m_mem[2 + (k - 1)]       : 8'd0;
    b0 = (k < 2)  ? m_mem[4 + 2 * k]         : 8'd0;
    b1 = (k >= 1) ? m_mem[4 + 2 * (k - 1) + 1] : 8'd0;
    return {1'b1, a0, a1, b0, b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    load_en = 1'b0;
    feed_en = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    m_vmask = 8'h00;
    tick();
  endtask

  task automatic do_load(input int a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a[2:0];
    load_data = d;
    tick();
    load_en   = 1'b0;
    m_mem[a]  = d;
    m_vmask[a] = 1'b1;
  endtask

  task automatic feed_done();
`ifndef OPBUF_REPLAY_EN
    m_vmask = 8'h00;
`endif
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 33'd0) begin
      errors++; $display("FAIL reset_ops got %h want 0", obs);
    end
    checks++;
    if (full !== 1'b0) begin
      errors++; $display("FAIL reset_full got %b want 0", full);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b want 0", err);
    end
  endtask

  task automatic test_basic_feed();
    for (int i = 0; i < 8; i++) do_load(i, 8'(i + 1));
    checks++;
    if (full !== 1'b1 || ops_valid !== 1'b0) begin
      errors++; $display("FAIL basic_full got %b/%b want 1/0", full, ops_valid);
    end
    feed_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== exp_ops(k)) begin
        errors++; $display("FAIL basic_ph%0d got %h want %h", k, obs, exp_ops(k));
      end
    end
    feed_done();
    checks++;
    if (full !== (m_vmask == 8'hFF)) begin
      errors++; $display("FAIL basic_full_after got %b want %b", full, m_vmask == 8'hFF);
    end
    feed_en = 1'b0;
    tick();
  endtask

  task automatic test_held_feed();
    do_reset();
    feed_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_load(i, 8'(i + 1));
      checks++;
      if (ops_valid !== 1'b0 || full !== (i == 7)) begin
        errors++; $display("FAIL held_load%0d got v%b f%b want v0 f%b", i, ops_valid, full, i == 7);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== exp_ops(k)) begin
        errors++; $display("FAIL held_ph%0d got %h want %h", k, obs, exp_ops(k));
      end
    end
    feed_done();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ops_valid !== 1'b0) begin
        errors++; $display("FAIL held_no_refeed got %b want 0", ops_valid);
      end
    end
    feed_en = 1'b0;
    tick();
  endtask

  task automatic test_partial();
    do_reset();
    for (int i = 0; i < 7; i++) do_load(i, 8'(i + 1));
    feed_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (ops_valid !== 1'b0 || full !== 1'b0) begin
        errors++; $display("FAIL partial_idle got v%b f%b want v0 f0", ops_valid, full);
      end
    end
    do_load(7, 8'd8);
    checks++;
    if (ops_valid !== 1'b0 || full !== 1'b1) begin
      errors++; $display("FAIL partial_ready got v%b f%b want v0 f1", ops_valid, full);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== exp_ops(k)) begin
        errors++; $display("FAIL partial_ph%0d got %h want %h", k, obs, exp_ops(k));
      end
    end
    feed_done();
    feed_en = 1'b0;
    tick();
  endtask

  task automatic test_load_during_feed();
    do_reset();
    for (int i = 0; i < 8; i++) do_load(i, 8'(i + 1));
    feed_en = 1'b1;
    tick();
    checks++;
    if (obs !== exp_ops(0) || err !== 1'b0) begin
      errors++; $display("FAIL lfeed_ph0 got %h e%b want %h e0", obs, err, exp_ops(0));
    end
    load_en   = 1'b1;
    load_addr = 3'd2;
    load_data = 8'h7F;
    tick();
    load_en   = 1'b0;
    checks++;
    if (obs !== exp_ops(1) || err !== 1'b1) begin
      errors++; $display("FAIL lfeed_ph1 got %h e%b want %h e1", obs, err, exp_ops(1));
    end
    for (int k = 2; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== exp_ops(k)) begin
        errors++; $display("FAIL lfeed_ph%0d got %h want %h", k, obs, exp_ops(k));
      end
    end
    feed_done();
    feed_en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL lfeed_err_sticky got %b want 1", err);
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 8; i++) do_load(i, 8'(i + 1));
    feed_en = 1'b1;
    tick();
    checks++;
    if (obs !== exp_ops(0)) begin
      errors++; $display("FAIL abort_ph0 got %h want %h", obs, exp_ops(0));
    end
    feed_en = 1'b0;
    tick();
    checks++;
    if (obs !== 33'd0 || full !== 1'b1) begin
      errors++; $display("FAIL abort_drop got %h f%b want 0 f1", obs, full);
    end
    feed_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== exp_ops(k)) begin
        errors++; $display("FAIL abort_replay_ph%0d got %h want %h", k, obs, exp_ops(k));
      end
    end
    feed_done();
    feed_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_feed();
    do_reset();
    for (int i = 0; i < 8; i++) do_load(i, 8'(i + 11));
    feed_en = 1'b1;
    tick();
    load_en   = 1'b1;
    load_addr = 3'd5;
    load_data = 8'hA5;
    tick();
    load_en   = 1'b0;
    checks++;
    if (obs !== exp_ops(1) || err !== 1'b1) begin
      errors++; $display("FAIL rmid_ph1 got %h e%b want %h e1", obs, err, exp_ops(1));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 33'd0 || full !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL rmid_async got %h f%b e%b want 0 f0 e0", obs, full, err);
    end
    feed_en = 1'b0;
    tick();
    rst_n   = 1'b1;
    m_vmask = 8'h00;
    tick();
  endtask

`ifdef OPBUF_REPLAY_EN
  task automatic test_replay();
    do_reset();
    for (int i = 0; i < 8; i++) do_load(i, 8'(i + 1));
    feed_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== exp_ops(k)) begin
        errors++; $display("FAIL replay_a_ph%0d got %h want %h", k, obs, exp_ops(k));
      end
    end
    tick();
    checks++;
    if (full !== 1'b1 || ops_valid !== 1'b0) begin
      errors++; $display("FAIL replay_hold got f%b v%b want f1 v0", full, ops_valid);
    end
    feed_en = 1'b0;
    tick();
    feed_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (obs !== exp_ops(k)) begin
        errors++; $display("FAIL replay_b_ph%0d got %h want %h", k, obs, exp_ops(k));
      end
    end
    feed_en = 1'b0;
    tick();
  endtask
`endif

  task automatic test_random();
    int perm [8];
    do_reset();
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        int j, t;
        j = int'($urandom_range(i, 0));
        t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int j = 0; j < 8; j++) begin
        if ($urandom_range(3, 0) == 0) tick();
        do_load(perm[j], 8'($urandom));
        if ($urandom_range(3, 0) == 0) do_load(perm[$urandom_range(j, 0)], 8'($urandom));
        if (j == 6) begin
          checks++;
          if (full !== (m_vmask == 8'hFF)) begin
            errors++; $display("FAIL rand%0d_full7 got %b want %b", it, full, m_vmask == 8'hFF);
          end
        end
      end
      checks++;
      if (full !== 1'b1) begin
        errors++; $display("FAIL rand%0d_full got %b want 1", it, full);
      end
      feed_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        checks++;
        if (obs !== exp_ops(k)) begin
          errors++; $display("FAIL rand%0d_ph%0d got %h want %h", it, k, obs, exp_ops(k));
        end
      end
      feed_done();
      checks++;
      if (full !== (m_vmask == 8'hFF)) begin
        errors++; $display("FAIL rand%0d_full_after got %b want %b", it, full, m_vmask == 8'hFF);
      end
      feed_en = 1'b0;
      tick();
    end
  endtask

  initial begin
    m_vmask = 8'h00;
    for (int i = 0; i < 8; i++) m_mem[i] = 8'h00;
    test_reset();
    test_basic_feed();
    test_held_feed();
    test_partial();
    test_load_during_feed();
    test_abort();
    test_reset_mid_feed();
`ifdef OPBUF_REPLAY_EN
    test_replay();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
